vc_arbiter: RTL and testbench
=============================

# vc_arbiter

Round-robin drain stage placed downstream of a bank of `NUM_IN` identical 8-entry FIFOs, one per virtual channel. It watches their `empty` flags, pops one word at a time, and forwards it to one of four destination FIFOs chosen by the word's low two bits. It throttles on the destinations' `almost_full` flags and paces its pops so each source FIFO's registered flags have settled before it is sampled again.

## Interface
- `NUM_IN`, 4: number of source FIFOs; legal range 2..8.
- `DATA_W`, 4: word width; must be ≥ 2.
- `clk`  input  1: single clock; everything samples on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `in_empty`  input  NUM_IN: `empty` flag of each source FIFO; bit i belongs to source i.
- `in_data`  input  NUM_IN*DATA_W: source read data, concatenated; source i occupies bits [i*DATA_W +: DATA_W]. Valid the cycle after that source's pop.
- `in_pop`  output  NUM_IN: pop strobes, registered; at most one bit high at a time.
- `out_almost_full`  input  4: `almost_full` of destination FIFOs 0..3.
- `out_data`  output  DATA_W: registered word to the destinations.
- `out_push`  output  4: push strobes, registered, one-hot or zero.
- `busy`  output  1: high whenever the FSM is not in ARB.
- `word_count`  output  8: number of words pushed, modulo 256.

## Operation
- FSM with three states: ARB → POP → CAPT → ARB. Encoding is free.
- ARB:
  - `req = ~in_empty`; `go = |req & ~|out_almost_full`.
  - If `go`: grant = first set bit of `req` at or after `ptr`, searching upward and wrapping from NUM_IN-1 to 0. Register `in_pop[grant] <= 1`, hold `grant`, next state POP.
  - Otherwise stay in ARB with `in_pop` all zero.
- POP:
  - `in_pop[grant]` is high for exactly this cycle.
  - Register `in_pop <= 0`; next state CAPT.
- CAPT:
  - Sample `w = in_data[grant*DATA_W +: DATA_W]`.
  - Register `out_data <= w` and `out_push[w[1:0]] <= 1`.
  - `ptr <= (grant == NUM_IN-1) ? 0 : grant+1`.
  - Next state ARB.
- `out_push` is high for one cycle only, then clears. `out_data` holds its value until the next capture.
- `word_count` increments by 1 in every cycle `out_push` is nonzero, wrapping 255 → 0.
- Backpressure:
  - `out_almost_full` is checked only in ARB, as a conservative all-destination gate.
  - Once a pop is issued, the word is always delivered, even if a destination becomes almost_full in the meantime. The downstream almost_full margin (≥ 2 free slots) absorbs it.
- No underflow or error detection here; the gating above guarantees a pop is never issued to an empty source.
- Reset values: state ARB, `ptr` 0, `in_pop` 0, `out_push` 0, `out_data` 0, `word_count` 0; `busy` therefore 0.

## Timing
- Decision in ARB at cycle t. `in_pop` high at t+1. `in_data` valid and captured at t+2. `out_push` and `out_data` valid at t+3.
- Cycle t+3 is also the next ARB, so a new `in_pop` can appear at t+4.
- Pop-to-push latency: 2 cycles. Peak throughput: 1 word per 3 cycles.
- The 3-cycle spacing is intentional. A source's `empty` reflects a pop at t+1 only from t+3 on, which is exactly the next ARB.
- Simultaneous requests: only one source is served per loop. Priority rotates to the source after the last one granted, so starvation-free: a requester waits at most NUM_IN-1 grants.
- Reset in any state takes effect at the next edge:
  - `in_pop` and `out_push` are 0 in the following cycle.
  - A captured or in-flight word is discarded and not counted.
  - A pop already seen by a source FIFO is not replayed.
- `busy` is combinational from state: 1 in POP and CAPT.

## Test plan
- Reset: hold `reset` 2 cycles with all sources non-empty → `in_pop`, `out_push`, `out_data`, `word_count` all 0. First `in_pop` = 4'b0001 one cycle after `reset` falls plus one ARB cycle.
- Single word: only source 2 non-empty, word 4'b1101 → `in_pop` = 4'b0100 at t+1, `out_data` = 4'b1101 and `out_push` = 4'b0010 at t+3, `word_count` = 1.
- Round robin: all four sources hold words 4'h0, 4'h5, 4'hA, 4'hF → pops in order 0,1,2,3,0. Pushes go to destinations 0,1,2,3, spaced 3 cycles apart.
- Backpressure: `out_almost_full` = 4'b1000 with source 1 non-empty → no `in_pop` while asserted. Pop occurs the cycle after it drops.
- Reset mid-operation: assert `reset` during CAPT → `out_push` stays 0, `word_count` unchanged, next grant restarts from source 0.
- Wrap: push 257 words through → `word_count` = 1. `ptr` wraps from 3 to 0 with no skipped source.

Source files
------------

// File: rtl/vc_arbiter.sv
// vc_arbiter: round-robin drain stage between NUM_IN source FIFOs and four
// destination FIFOs. One word is moved per ARB -> POP -> CAPT loop. The
// destination is chosen by the word's low two bits. Pops are paced so each
// source's registered empty flag has settled before it is sampled again.
module vc_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_empty,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_pop,
  input  logic [3:0]               out_almost_full,
  output logic [DATA_W-1:0]        out_data,
  output logic [3:0]               out_push,
  output logic                     busy,
  output logic [7:0]               word_count
);

  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {ARB, POP, CAPT} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr, grant, pick, cand;
  logic [NUM_IN-1:0] req;
  logic              go, found;
  int unsigned       idx;
  logic [DATA_W-1:0] cap_word;
  logic [DATA_W-1:0] src_word [NUM_IN];

  assign req  = ~in_empty;
  assign go   = |req & ~|out_almost_full;
  assign busy = (state != ARB);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_split
    assign src_word[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Pick the first requester at or after ptr, wrapping past NUM_IN-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx  = (32'(ptr) + k) % NUM_IN;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Select the word of the granted source.
  always_comb begin
    cap_word = src_word[grant];
  end

  // Next-state logic for the three-phase transfer loop.
  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (go) state_next = POP;
      POP:     state_next = CAPT;
      CAPT:    state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  // Registered strobes, data, pointer and counter.
  // word_count is bumped on the same edge that raises out_push, so the count
  // already includes the word being pushed in the cycle the strobe is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_pop     <= '0;
      out_push   <= '0;
      out_data   <= '0;
      word_count <= '0;
      ptr        <= '0;
      grant      <= '0;
    end else begin
      in_pop   <= '0;
      out_push <= '0;
      case (state)
        ARB: begin
          if (go) begin
            grant  <= pick;
            in_pop <= NUM_IN'(1) << pick;
          end
        end
        CAPT: begin
          out_data   <= cap_word;
          out_push   <= 4'b0001 << cap_word[1:0];
          word_count <= word_count + 8'd1;
          ptr        <= (grant == IDX_W'(NUM_IN-1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Testbench for vc_arbiter: source FIFO models, transaction-level reference
// model feeding expected pops/pushes into queues, separate monitor checking.
module tb_vc_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_pop;
  logic [3:0]     out_almost_full;
  logic [W-1:0]   out_data;
  logic [3:0]     out_push;
  logic           busy;
  logic [7:0]     word_count;

  vc_arbiter #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data),
    .in_pop(in_pop), .out_almost_full(out_almost_full), .out_data(out_data),
    .out_push(out_push), .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int src; } pop_t;
  typedef struct { int cyc; logic [W-1:0] data; logic [7:0] cnt; } push_t;

  pop_t  popq[$];
  push_t pushq[$];

  // Source FIFO models (8-entry rings).
  logic [W-1:0] fmem [N][8];
  int           fcnt [N];
  int           fhead[N];
  logic [W-1:0] data_r[N];

  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  int         mbusy = 0;
  int         mptr = 0;
  logic [7:0] mcount = '0;
  bit         exp_busy = 1'b0;
  bit         mon_en = 1'b0;
  bit         rst_req = 1'b1;
  bit         capt_reset = 1'b0;
  logic [3:0] af_val = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic add_word(int i, logic [W-1:0] w);
    if (fcnt[i] < 8) begin
      fmem[i][(fhead[i] + fcnt[i]) % 8] = w;
      fcnt[i]++;
    end
  endtask

  function automatic int pending();
    int p = popq.size() + pushq.size() + mbusy;
    for (int i = 0; i < N; i++) p += fcnt[i];
    return p;
  endfunction

  // One cycle: FIFO reaction, input drive, reference model step.
  task automatic step();
    int g;
    bit any;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (in_pop[i] === 1'b1 && fcnt[i] > 0) begin
        data_r[i] = fmem[i][fhead[i]];
        fhead[i]  = (fhead[i] + 1) % 8;
        fcnt[i]--;
      end
    end
    reset = rst_req;
    if (capt_reset && mbusy == 1) begin
      reset      = 1'b1;
      capt_reset = 1'b0;
    end
    out_almost_full = af_val;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_empty[i]        = (fcnt[i] == 0);
      in_data[i*W +: W]  = data_r[i];
      if (fcnt[i] > 0) any = 1'b1;
    end
    exp_busy = (mbusy != 0);
    if (reset) begin
      mbusy  = 0;
      mptr   = 0;
      mcount = '0;
      while (popq.size() > 0 && popq[$].cyc > cyc) void'(popq.pop_back());
      while (pushq.size() > 0 && pushq[$].cyc > cyc) void'(pushq.pop_back());
    end else if (mbusy > 0) begin
      mbusy--;
    end else if (af_val == 4'b0000 && any) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && fcnt[(mptr + k) % N] > 0) g = (mptr + k) % N;
      mcount++;
      popq.push_back('{cyc + 1, g});
      pushq.push_back('{cyc + 3, fmem[g][fhead[g]], mcount});
      mptr  = (g + 1) % N;
      mbusy = 2;
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      step();
      #3;
      n++;
    end while (pending() != 0 && n < budget);
    chk("idle_timeout", pending(), 0);
  endtask

  // Monitor: compare DUT strobes against the expected queues.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("busy", 32'(busy), 32'(exp_busy));
        if (popq.size() > 0 && popq[0].cyc == cyc) begin
          chk("pop_grant", 32'(in_pop), 32'(1) << popq[0].src);
          void'(popq.pop_front());
        end else if (in_pop !== '0) begin
          chk("pop_unexpected", 32'(in_pop), 0);
        end
        if (pushq.size() > 0 && pushq[0].cyc == cyc) begin
          chk("push_dest", 32'(out_push), 32'(1) << pushq[0].data[1:0]);
          chk("push_data", 32'(out_data), 32'(pushq[0].data));
          chk("push_count", 32'(word_count), 32'(pushq[0].cnt));
          void'(pushq.pop_front());
        end else if (out_push !== '0) begin
          chk("push_unexpected", 32'(out_push), 0);
        end
      end
    end
  end

  initial begin
    int added;
    int guard;
    reset = 1'b1;
    in_empty = '1;
    in_data = '0;
    out_almost_full = '0;
    for (int i = 0; i < N; i++) begin
      data_r[i] = '0;
      fcnt[i]   = 0;
      fhead[i]  = 0;
    end

    // Reset with every source non-empty; contents double as the round-robin test.
    add_word(0, 4'h0);
    add_word(1, 4'h5);
    add_word(2, 4'hA);
    add_word(3, 4'hF);
    add_word(0, 4'h8);
    rst_req = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    chk("rst_in_pop", 32'(in_pop), 0);
    chk("rst_out_push", 32'(out_push), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_word_count", 32'(word_count), 0);
    rst_req = 1'b0;
    wait_idle(200);

    // Single word from source 2.
    add_word(2, 4'b1101);
    wait_idle(100);
    chk("single_count", 32'(word_count), 6);

    // Backpressure: no pop while any destination is almost full.
    af_val = 4'b1000;
    add_word(1, 4'($urandom));
    repeat (8) step();
    af_val = 4'b0000;
    wait_idle(100);

    // Reset during CAPT: word discarded, grant restarts from source 0.
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    add_word(1, 4'($urandom));
    add_word(3, 4'($urandom));
    capt_reset = 1'b1;
    wait_idle(100);
    chk("midrst_count", 32'(word_count), 1);

    // Counter wrap: 256 more words makes 257 since the last reset.
    added = 0;
    guard = 0;
    while (added < 256 && guard < 5000) begin
      int s = $urandom_range(0, N - 1);
      if (fcnt[s] < 8) begin
        add_word(s, 4'($urandom));
        added++;
      end
      step();
      guard++;
    end
    wait_idle(3000);
    chk("wrap_count", 32'(word_count), 1);

    // Random traffic, backpressure and occasional resets.
    repeat (400) begin
      af_val  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rst_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) add_word($urandom_range(0, N - 1), 4'($urandom));
      step();
    end
    rst_req = 1'b0;
    af_val  = 4'b0000;
    wait_idle(500);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
